// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, keeps one imem request in flight and feeds decode
// through a 2-entry fetch buffer with same-edge bypass when the buffer is empty.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [63:0] r_buf [2];
    logic [1:0]  r_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_push;
    logic [63:0] w_entry;
    logic        w_avail;
    logic [63:0] w_head;
    logic        w_pop;
    logic [1:0]  w_occ;
    logic        w_issue;
    logic        w_wr_en;
    logic        w_wr_idx;

    // A redirect empties the buffer, so wrong-path entries are never offered to decode.
    always_comb begin
        w_redirect = PCSrcW | BranchTakenE;
        w_target   = PCSrcW ? ResultW : BranchTargetE;
        w_push     = r_state == WAIT && imem_valid && !w_redirect;
        w_entry    = {imem_rdata, r_req_addr + 32'd8};
        w_avail    = w_push || (r_count != 2'd0 && !w_redirect);
        w_head     = r_count != 2'd0 ? r_buf[0] : w_entry;
        w_pop      = w_avail && !StallD && !FlushD;
        w_occ      = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_issue    = reset && !StallF && !w_redirect && (r_state == IDLE || imem_valid) && w_occ < 2'd2;
        w_wr_en    = w_push && !(w_pop && r_count == 2'd0);
        w_wr_idx   = r_count == 2'd2 || (r_count == 2'd1 && !w_pop);
        imem_req   = w_issue;
        imem_addr  = r_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            InstrD   <= 32'd0;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else begin
            r_state <= w_issue ? WAIT :
                       (r_state == IDLE || imem_valid) ? IDLE :
                       (r_state == WAIT && w_redirect) ? DROP : r_state;
            r_pc    <= w_redirect ? w_target : w_issue ? r_pc + 32'd4 : r_pc;
            r_count <= w_redirect ? 2'd0 : w_occ;
            if (w_issue)
                r_req_addr <= r_pc;
            if (w_pop)
                r_buf[0] <= r_buf[1];
            if (w_wr_en)
                r_buf[w_wr_idx] <= w_entry;
            if (FlushD)
                {InstrD, PCPlus8D, ValidD} <= 65'd0;
            else if (!StallD)
                {InstrD, PCPlus8D, ValidD} <= w_avail ? {w_head, 1'b1} : 65'd0;
        end
    end
endmodule
